muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised, iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the integer ALU in the EX stage. The pipeline stalls while this unit is busy, and the unit can be killed by a pipeline flush.
- Uses radix-2 shift-add multiply and restoring divide, one bit per cycle, with a valid/ready handshake on both input and output.

Parameters:
- XLEN, 32, operand and result width (must be ≥ 4).
- CNT_W, $clog2(XLEN)+1, width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- op  in  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand (multiplicand / dividend).
- b  in  XLEN  rs2 operand (multiplier / divisor).
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  operation result.
- div_by_zero  out  1  sideband flag, qualified by out_valid; set when a divide/remainder had b == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; in_ready = 1; out_valid = 0; result = 0; div_by_zero = 0; counter and all datapath registers = 0.
- States:
  - IDLE: a request is accepted when in_valid && in_ready. Operands and op are latched.
    - Special divide case → FAST.
    - Any other operation → CALC with counter = XLEN.
  - FAST: one cycle. Writes the special-case result, then → DONE.
  - CALC: one bit per cycle; counter decrements; when counter reaches 1, → FIX.
  - FIX: applies sign correction and selects the low/high half or quotient/remainder; → DONE.
  - DONE: out_valid = 1 with result stable. Leaves to IDLE in the cycle where out_ready is high.
- Signedness rules:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Datapath: signed operands are converted to magnitudes at acceptance, and the result is negated in FIX.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Multiply: 2·XLEN-bit accumulator. MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Divide: restoring algorithm with a (XLEN+1)-bit partial remainder.
- Latency (acceptance edge = cycle 0):
  - Normal operation: out_valid first high in cycle XLEN+2 (34 for XLEN=32).
  - FAST path: out_valid high in cycle 2.
- Special cases (FAST path):
  - b == 0:
    - DIV/DIVU result = all ones.
    - REM/REMU result = a.
    - div_by_zero = 1.
  - Signed overflow (a == most-negative value and b == -1):
    - DIV result = a.
    - REM result = 0.
    - div_by_zero = 0.
- Handshake:
  - in_ready = (state == IDLE).
  - result and div_by_zero stay stable while out_valid && !out_ready.
  - No new request is accepted in the same cycle a result is consumed; the next accept is possible one cycle later.
- Flush:
  - Takes priority over every other event in any state: next state = IDLE, out_valid = 0, the result is discarded.
  - flush together with in_valid in IDLE: the request is not accepted.
- Reset mid-operation: immediate return to the reset values; no partial result is ever presented.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) → result 0xFFFFFFEB at cycle 34; MULH with the same operands → 0xFFFFFFFF; MULHU → 0x00000006.
- DIV a=-20, b=3 → 0xFFFFFFFA (-6); REM → 0xFFFFFFFE (-2); DIVU a=100, b=7 → 14; REMU → 2.
- DIVU a=5, b=0 → 0xFFFFFFFF with div_by_zero=1 at cycle 2; REM a=5, b=0 → 5; DIV a=0x80000000, b=-1 → 0x80000000 with div_by_zero=0.
- Hold out_ready=0 for 10 cycles after out_valid → result stable and in_ready=0 throughout; raise out_ready → in_ready=1 on the next cycle.
- Assert flush in cycle 15 of a DIV → IDLE next cycle with out_valid never asserted; a following MULHSU a=-1, b=2 → 0xFFFFFFFF.
- Pulse rst_n low in cycle 10 of a MUL (asynchronous, mid-cycle) → outputs take their reset values immediately. Repeat the MUL/DIV cases with XLEN=8, e.g. MUL 0x7F×0x02 → 0xFE at cycle 10.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, valid/ready on both sides.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            div_by_zero
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] FAST = 3'd1;
   localparam logic [2:0] CALC = 3'd2;
   localparam logic [2:0] FIX  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [2:0]        state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [2:0]        op_reg;
   logic [2*XLEN-1:0] acc_reg;
   logic [XLEN-1:0]   rem_reg;
   logic [XLEN-1:0]   dsr_reg;
   logic              neg_q_reg;
   logic              neg_r_reg;
   logic              dbz_reg;
   logic [XLEN-1:0]   result_reg;
   logic              div_by_zero_reg;

   logic              a_signed;
   logic              b_signed;
   logic              a_neg;
   logic              b_neg;
   logic              b_zero;
   logic              sgn_ovf;
   logic              special;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_acc_next;
   logic [XLEN:0]     div_shift;
   logic [XLEN+1:0]   div_diff;
   logic [XLEN-1:0]   div_rem_next;
   logic [2*XLEN-1:0] div_acc_next;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rmd_fix;
   logic [XLEN-1:0]   fix_next;
   logic [XLEN-1:0]   fast_next;

   assign in_ready    = (state_reg == IDLE);
   assign out_valid   = (state_reg == DONE);
   assign result      = result_reg;
   assign div_by_zero = div_by_zero_reg;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (op)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
   end

   assign a_neg   = a_signed & a[XLEN-1];
   assign b_neg   = b_signed & b[XLEN-1];
   assign a_mag   = a_neg ? (~a + 1'b1) : a;
   assign b_mag   = b_neg ? (~b + 1'b1) : b;
   assign b_zero  = (b == '0);
   assign sgn_ovf = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (&b);
   assign special = op[2] && (b_zero || sgn_ovf);

   // Multiply: low half of acc holds the multiplier, high half accumulates, shift right each step.
   always_comb begin
      mul_sum      = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, dsr_reg} : '0);
      mul_acc_next = {mul_sum, acc_reg[XLEN-1:1]};
   end

   // Divide: dividend shifts out of acc's low half MSB-first while quotient bits shift in.
   always_comb begin
      div_shift = {rem_reg, acc_reg[XLEN-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, dsr_reg};
      if (div_diff[XLEN+1]) begin
         div_rem_next = div_shift[XLEN-1:0];
      end else begin
         div_rem_next = div_diff[XLEN-1:0];
      end
      div_acc_next = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-2:0], ~div_diff[XLEN+1]};
   end

   always_comb begin
      prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
      quo_fix  = neg_q_reg ? (~acc_reg[XLEN-1:0] + 1'b1) : acc_reg[XLEN-1:0];
      rmd_fix  = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
      fix_next = '0;
      case (op_reg)
         OP_MUL:          fix_next = prod_fix[XLEN-1:0];
         OP_DIV, OP_DIVU: fix_next = quo_fix;
         3'b110, 3'b111:  fix_next = rmd_fix;
         default:         fix_next = prod_fix[2*XLEN-1:XLEN];
      endcase
   end

   // Fast path keeps the raw dividend in acc; op bit 1 separates remainder from quotient.
   always_comb begin
      if (dbz_reg) begin
         fast_next = op_reg[1] ? acc_reg[XLEN-1:0] : '1;
      end else begin
         fast_next = op_reg[1] ? '0 : acc_reg[XLEN-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         op_reg          <= '0;
         acc_reg         <= '0;
         rem_reg         <= '0;
         dsr_reg         <= '0;
         neg_q_reg       <= 1'b0;
         neg_r_reg       <= 1'b0;
         dbz_reg         <= 1'b0;
         result_reg      <= '0;
         div_by_zero_reg <= 1'b0;
      end else if (flush) begin
         state_reg <= IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  op_reg    <= op;
                  cnt_reg   <= CNT_W'(XLEN);
                  rem_reg   <= '0;
                  neg_q_reg <= a_neg ^ b_neg;
                  neg_r_reg <= a_neg;
                  dbz_reg   <= op[2] & b_zero;
                  if (op[2]) begin
                     acc_reg <= {{XLEN{1'b0}}, (special ? a : a_mag)};
                     dsr_reg <= b_mag;
                  end else begin
                     acc_reg <= {{XLEN{1'b0}}, b_mag};
                     dsr_reg <= a_mag;
                  end
                  state_reg <= special ? FAST : CALC;
               end
            end
            FAST: begin
               result_reg      <= fast_next;
               div_by_zero_reg <= dbz_reg;
               state_reg       <= DONE;
            end
            CALC: begin
               if (op_reg[2]) begin
                  acc_reg <= div_acc_next;
                  rem_reg <= div_rem_next;
               end else begin
                  acc_reg <= mul_acc_next;
               end
               cnt_reg <= cnt_reg - 1'b1;
               if (cnt_reg == CNT_W'(1)) begin
                  state_reg <= FIX;
               end
            end
            FIX: begin
               result_reg      <= fix_next;
               div_by_zero_reg <= 1'b0;
               state_reg       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at XLEN=32 and XLEN=8 against a plain-arithmetic model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        sel = 1'b0;   // 0: 32-bit unit under test, 1: 8-bit unit

   logic        ir32, ov32, dz32, ir8, ov8, dz8;
   logic [31:0] res32;
   logic [7:0]  res8;
   logic        in_ready_m, out_valid_m, dz_m;
   logic [31:0] result_m;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   bit started = 1'b0;

   typedef struct {
      logic [31:0] r;
      logic        dz;
      int          lat;
      int          acc;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   muldiv_unit #(.XLEN(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(ir32),
      .op(op), .a(a), .b(b), .flush(flush), .out_valid(ov32),
      .out_ready(out_ready), .result(res32), .div_by_zero(dz32));

   muldiv_unit #(.XLEN(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(ir8),
      .op(op), .a(a[7:0]), .b(b[7:0]), .flush(flush), .out_valid(ov8),
      .out_ready(out_ready), .result(res8), .div_by_zero(dz8));

   assign in_ready_m  = sel ? ir8 : ir32;
   assign out_valid_m = sel ? ov8 : ov32;
   assign dz_m        = sel ? dz8 : dz32;
   assign result_m    = sel ? {24'd0, res8} : res32;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: RV32M semantics evaluated with 64-bit integer arithmetic.
   function automatic exp_t model(input int xl, input logic [2:0] o,
                                  input logic [31:0] ai, input logic [31:0] bi);
      exp_t e;
      longint full, half, ua, ub, sa, sb;
      logic [63:0] p;
      full = longint'(1) << xl;
      half = full >> 1;
      ua = longint'({32'd0, ai}) & (full - 1);
      ub = longint'({32'd0, bi}) & (full - 1);
      sa = (ua >= half) ? ua - full : ua;
      sb = (ub >= half) ? ub - full : ub;
      e.dz = 1'b0;
      e.lat = xl + 2;
      e.acc = 0;
      e.r = '0;
      p = '0;
      case (o)
         3'b000: begin p = 64'(sa * sb); e.r = 32'(p & 64'(full - 1)); end
         3'b001: begin p = 64'(sa * sb); e.r = 32'((p >> xl) & 64'(full - 1)); end
         3'b010: begin p = 64'(sa * ub); e.r = 32'((p >> xl) & 64'(full - 1)); end
         3'b011: begin p = 64'(ua * ub); e.r = 32'((p >> xl) & 64'(full - 1)); end
         3'b100, 3'b110: begin
            if (ub == 0) begin
               e.dz = 1'b1; e.lat = 2;
               e.r = (o == 3'b100) ? 32'(full - 1) : 32'(ua);
            end else if (sa == -half && sb == -1) begin
               e.lat = 2;
               e.r = (o == 3'b100) ? 32'(ua) : 32'd0;
            end else begin
               e.r = (o == 3'b100) ? 32'((sa / sb) & (full - 1)) : 32'((sa % sb) & (full - 1));
            end
         end
         default: begin
            if (ub == 0) begin
               e.dz = 1'b1; e.lat = 2;
               e.r = (o == 3'b101) ? 32'(full - 1) : 32'(ua);
            end else begin
               e.r = (o == 3'b101) ? 32'(ua / ub) : 32'(ua % ub);
            end
         end
      endcase
      return e;
   endfunction

   // Per-cycle compare: busy/idle, out_valid timing, result and flag against the scoreboard.
   always @(negedge clk) begin
      bit idle;
      int el;
      exp_t e;
      if (started && rst_n) begin
         idle = (sb_q.size() == 0);
         if (idle) begin
            chk("in_ready_idle", in_ready_m, 1'b1);
            chk("out_valid_idle", out_valid_m, 1'b0);
         end else begin
            el = cyc - sb_q[0].acc + 1;
            chk("in_ready_busy", in_ready_m, 1'b0);
            chk("out_valid_timing", out_valid_m, (el >= sb_q[0].lat));
            if (out_valid_m) begin
               chk("result", result_m, sb_q[0].r);
               chk("div_by_zero", dz_m, sb_q[0].dz);
            end
         end
         if (flush) begin
            sb_q.delete();
         end else if (!idle && out_valid_m && out_ready) begin
            void'(sb_q.pop_front());
         end else if (idle && in_valid) begin
            e = model(sel ? 8 : 32, op, a, b);
            e.acc = cyc + 1;
            sb_q.push_back(e);
         end
      end
   end

   // Issue one request, wait for its result, stall out_ready for 'hold' cycles, then consume.
   task automatic do_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input int hold, input bit lit_en, input logic [31:0] lit_r, input logic lit_dz);
      int t;
      logic [31:0] cap;
      in_valid = 1'b1; op = o; a = aa; b = bb;
      t = 0;
      while (!in_ready_m && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      t = 0;
      while (!out_valid_m && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) begin
         chk("result_timeout", 32'd0, 32'd1);
         return;
      end
      cap = result_m;
      $display("xlen=%0d op=%0d a=%h b=%h result=%h dz=%b", sel ? 8 : 32, o, aa, bb, result_m, dz_m);
      if (lit_en) begin
         chk("literal_result", result_m, lit_r);
         chk("literal_dz", dz_m, lit_dz);
      end
      repeat (hold) begin @(posedge clk); #1; end
      if (hold > 0) chk("hold_stable", result_m, cap);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("in_ready_after_pop", in_ready_m, 1'b1);
   endtask

   task automatic run_dir(input bit s8, input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] r, input logic dz, input int hold);
      exp_t e;
      e = model(s8 ? 8 : 32, o, aa, bb);
      chk("model_pin_result", e.r, r);
      chk("model_pin_dz", e.dz, dz);
      sel = s8;
      do_op(o, aa, bb, hold, 1'b1, r, dz);
   endtask

   function automatic logic [31:0] rnd_opnd(input int xl);
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'd1 << (xl - 1);
         3: return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int t;
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      chk("reset_in_ready32", ir32, 1'b1);
      chk("reset_out_valid32", ov32, 1'b0);
      chk("reset_result32", res32, 32'd0);
      chk("reset_dz32", dz32, 1'b0);
      chk("reset_in_ready8", ir8, 1'b1);
      chk("reset_out_valid8", ov8, 1'b0);
      chk("reset_result8", {24'd0, res8}, 32'd0);
      chk("reset_dz8", dz8, 1'b0);
      rst_n = 1'b1;
      started = 1'b1;
      @(posedge clk); #1;

      run_dir(0, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0);
      run_dir(0, 3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
      run_dir(0, 3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 1'b0, 10);
      run_dir(0, 3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b0, 0);
      run_dir(0, 3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 1'b0, 0);
      run_dir(0, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 0);
      run_dir(0, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 0);
      run_dir(0, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
      run_dir(0, 3'b110, 32'd5, 32'd0, 32'd5, 1'b1, 3);
      run_dir(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
      run_dir(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);

      // Flush part-way through a divide; nothing may come out.
      sel = 1'b0;
      in_valid = 1'b1; op = 3'b100; a = 32'hFFFF_FC18; b = 32'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (14) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_ready", in_ready_m, 1'b1);
      chk("flush_out_valid", out_valid_m, 1'b0);
      repeat (40) begin @(posedge clk); #1; end
      run_dir(0, 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);

      // Flush alongside a request in IDLE: request is dropped.
      in_valid = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_noaccept_ready", in_ready_m, 1'b1);
      repeat (5) begin @(posedge clk); #1; end

      // Flush while a result waits in DONE.
      in_valid = 1'b1; op = 3'b101; a = 32'd5; b = 32'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      t = 0;
      while (!out_valid_m && t < 10) begin @(posedge clk); #1; t++; end
      chk("fast_valid_seen", out_valid_m, 1'b1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_done_valid", out_valid_m, 1'b0);

      // Asynchronous reset mid-multiply, between clock edges.
      in_valid = 1'b1; op = 3'b000; a = 32'h1234_5678; b = 32'h0000_0100;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      sb_q.delete();
      #1;
      chk("midreset_in_ready", ir32, 1'b1);
      chk("midreset_out_valid", ov32, 1'b0);
      chk("midreset_result", res32, 32'd0);
      chk("midreset_dz", dz32, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_dir(0, 3'b000, 32'h1234_5678, 32'h0000_0100, 32'h3456_7800, 1'b0, 0);

      for (int i = 0; i < 120; i++) begin
         do_op(3'($urandom_range(0, 7)), rnd_opnd(32), rnd_opnd(32), $urandom_range(0, 3), 1'b0, '0, 1'b0);
      end

      run_dir(1, 3'b000, 32'h7F, 32'h02, 32'hFE, 1'b0, 0);
      run_dir(1, 3'b001, 32'h7F, 32'h02, 32'h00, 1'b0, 0);
      run_dir(1, 3'b011, 32'hFF, 32'hFF, 32'hFE, 1'b0, 0);
      run_dir(1, 3'b100, 32'hEC, 32'h03, 32'hFA, 1'b0, 0);
      run_dir(1, 3'b110, 32'hEC, 32'h03, 32'hFE, 1'b0, 2);
      run_dir(1, 3'b101, 32'h64, 32'h07, 32'h0E, 1'b0, 0);
      run_dir(1, 3'b100, 32'h80, 32'hFF, 32'h80, 1'b0, 0);
      run_dir(1, 3'b111, 32'h05, 32'h00, 32'h05, 1'b1, 0);

      for (int i = 0; i < 150; i++) begin
         do_op(3'($urandom_range(0, 7)), rnd_opnd(8), rnd_opnd(8), $urandom_range(0, 3), 1'b0, '0, 1'b0);
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
